// File: rtl/mem_bus_interface.sv
// Memory-side bus stage: latches address/write data from SysBus, runs a Req/Ack
// handshake with timeout to external memory, and returns registered read data.
module mem_bus_interface #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] SysBus,
  input  logic        AddrWe,
  input  logic        AddrInc,
  input  logic        ReadReq,
  input  logic        WriteReq,
  input  logic        ErrClr,
  output logic [15:0] MemData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  output logic        MemReq,
  output logic        MemWrite,
  input  logic [15:0] MemRData,
  input  logic        MemAck
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] wdr_q, wdr_d;
  logic [15:0] mdata_q, mdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    wdr_d   = wdr_q;
    mdata_d = mdata_q;
    done_d  = 1'b0;
    err_d   = err_q & ~ErrClr;
    unique case (state_q)
      ST_IDLE: begin
        // An accepted request freezes MAR so the transaction uses the pre-edge address.
        if (WriteReq) begin
          wdr_d   = SysBus;
          cnt_d   = '0;
          state_d = ST_WR;
        end else if (ReadReq) begin
          cnt_d   = '0;
          state_d = ST_RD;
        end else if (AddrWe) begin
          mar_d = SysBus;
        end else if (AddrInc) begin
          mar_d = mar_q + 16'd1;
        end
      end
      ST_RD, ST_WR: begin
        cnt_d = cnt_q + 8'd1;
        if (MemAck) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (state_q == ST_RD) mdata_d = MemRData;
        end else if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
          if (state_q == ST_RD) mdata_d = ERR_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      wdr_q   <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      wdr_q   <= wdr_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign MemReq   = Busy;
  assign MemWrite = (state_q == ST_WR);
  assign MemAddr  = mar_q;
  assign MemWData = wdr_q;
  assign MemData  = mdata_q;
  assign Done     = done_q;
  assign Error    = err_q;

endmodule
